// File: rtl/sram_pkg.sv
// sram_pkg
// Shared types and constants for the FFT buffer SRAM scheduler:
//   sfp_t       - one fixed-point sample component
//   addr_t_long - long-bank address
//   cmd_t       - scheduler command {col, idx, base, len}
//   state_t     - scheduler FSM states
//   LongDepth / ShortDepth - bank depths
//   WEN_COL / REN_COL0     - one-hot column selects
package sram_pkg;

    localparam int LongDepth  = 128;
    localparam int ShortDepth = 32;

    localparam logic [4:0] WEN_COL  = 5'b10000;
    localparam logic [7:0] REN_COL0 = 8'h10;

    typedef logic [15:0] sfp_t;
    typedef logic [$clog2(LongDepth)-1:0] addr_t_long;

    typedef struct packed {
        logic       col;   // 0 = row mode, 1 = column mode
        logic [1:0] idx;   // row or column number
        addr_t_long base;  // first address
        logic [7:0] len;   // beat count, 1..128
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/sram_access_sched_if.sv
// sram_access_sched_if
// Requester-side bundle of the scheduler: the write and read command
// channels, the write beat stream and the read beat return.
// Signal suffixes are from the scheduler's point of view.
//   master - requester side (drives commands and write beats)
//   slave  - scheduler side
interface sram_access_sched_if;
    import sram_pkg::*;

    logic       wr_cmd_valid_i;
    logic       wr_cmd_ready_o;
    cmd_t       wr_cmd_i;
    logic       rd_cmd_valid_i;
    logic       rd_cmd_ready_o;
    cmd_t       rd_cmd_i;

    logic       wr_valid_i;
    logic       wr_ready_o;
    sfp_t [3:0] wr_dr_i;
    sfp_t [3:0] wr_di_i;

    logic       rd_valid_o;
    logic       rd_last_o;
    sfp_t [3:0] rd_dr_o;
    sfp_t [3:0] rd_di_o;

    modport master (
        output wr_cmd_valid_i, wr_cmd_i, rd_cmd_valid_i, rd_cmd_i,
        output wr_valid_i, wr_dr_i, wr_di_i,
        input  wr_cmd_ready_o, rd_cmd_ready_o, wr_ready_o,
        input  rd_valid_o, rd_last_o, rd_dr_o, rd_di_o
    );

    modport slave (
        input  wr_cmd_valid_i, wr_cmd_i, rd_cmd_valid_i, rd_cmd_i,
        input  wr_valid_i, wr_dr_i, wr_di_i,
        output wr_cmd_ready_o, rd_cmd_ready_o, wr_ready_o,
        output rd_valid_o, rd_last_o, rd_dr_o, rd_di_o
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. Exactly one grant is always high:
// a lone requester wins, and with both or neither requesting the side
// that was not granted last is chosen. The pointer only moves when
// update_i is high, so a grant that is not taken up leaves it alone.
//   clk_i, rst_i - clock, synchronous active-high reset
//   req_i[1:0]   - requests (bit 0 write, bit 1 read)
//   update_i     - record the current grant as "last granted"
//   gnt_o[1:0]   - one-hot grant
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // 1 = read was granted last, so write is favoured (reset value).
    logic last_rd_reg;
    logic last_rd_next;

    always_comb begin
        gnt_o = 2'b01;
        if (req_i == 2'b01) begin
            gnt_o = 2'b01;
        end else if (req_i == 2'b10) begin
            gnt_o = 2'b10;
        end else begin
            gnt_o = last_rd_reg ? 2'b01 : 2'b10;
        end
        last_rd_next = update_i ? gnt_o[1] : last_rd_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_rd_reg <= 1'b1;
        end else begin
            last_rd_reg <= last_rd_next;
        end
    end

endmodule

// File: rtl/sram_access_sched.sv
// sram_access_sched
// Owns the single-port FFT buffer SRAM and shares it between the
// butterfly output stream (writes) and input stream (reads). Whole
// commands are arbitrated round-robin, checked against bank depth, then
// executed one beat per cycle.
//   clk_i, rst_i          - clock, synchronous active-high reset
//   req                   - requester bundle (commands, write beats, read return)
//   wen_o, addr_wr_o,
//   dr_sram_o, di_sram_o  - registered SRAM write side
//   ren_o, addr_rd_o      - registered SRAM read side
//   dr_sram_i, di_sram_i  - SRAM read data, RdLatency after ren/addr
//   busy_o                - FSM not in IDLE
//   err_o                 - one-cycle pulse after an illegal command is consumed
module sram_access_sched
    import sram_pkg::*;
#(
    parameter int AddrLWidth = 7,
    parameter int AddrSWidth = 5,
    parameter int RdLatency  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sram_access_sched_if.slave   req,
    output logic [4:0]           wen_o,
    output addr_t_long           addr_wr_o,
    output sfp_t [3:0]           dr_sram_o,
    output sfp_t [3:0]           di_sram_o,
    output logic [7:0]           ren_o,
    output addr_t_long           addr_rd_o,
    input  sfp_t [3:0]           dr_sram_i,
    input  sfp_t [3:0]           di_sram_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int LongLim  = 1 << AddrLWidth;
    localparam int ShortLim = 1 << AddrSWidth;
    localparam int DW       = $clog2(RdLatency + 1);

    state_t          state_reg, state_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic [7:0]      len_reg, len_next;
    addr_t_long      base_reg, base_next;
    logic [4:0]      wsel_reg, wsel_next;
    logic [4:0]      wen_reg, wen_next;
    addr_t_long      addr_wr_reg, addr_wr_next;
    sfp_t [3:0]      dr_reg, dr_next;
    sfp_t [3:0]      di_reg, di_next;
    logic [7:0]      ren_reg, ren_next;
    addr_t_long      addr_rd_reg, addr_rd_next;
    logic [DW-1:0]   drain_reg, drain_next;
    logic            err_reg, err_next;
    logic [RdLatency-1:0] vpipe_reg;
    logic [RdLatency-1:0] lpipe_reg;

    logic [1:0] gnt;
    cmd_t       cmd_sel;
    logic       cmd_take;
    logic       legal;
    logic [8:0] end_addr;
    logic [8:0] limit;
    logic       last_beat;
    logic       issue;
    logic       issue_last;

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({req.rd_cmd_valid_i, req.wr_cmd_valid_i}),
        .update_i (cmd_take && legal),
        .gnt_o    (gnt)
    );

    // Command readiness is held low while reset is asserted.
    assign req.wr_cmd_ready_o = (state_reg == IDLE) && !rst_i && gnt[0];
    assign req.rd_cmd_ready_o = (state_reg == IDLE) && !rst_i && gnt[1];
    assign req.wr_ready_o     = (state_reg == WRITE);

    assign cmd_sel  = gnt[1] ? req.rd_cmd_i : req.wr_cmd_i;
    assign cmd_take = (req.wr_cmd_ready_o && req.wr_cmd_valid_i) ||
                      (req.rd_cmd_ready_o && req.rd_cmd_valid_i);

    // 9-bit sum so base+len can never wrap past the limit.
    assign end_addr = {2'b00, cmd_sel.base} + {1'b0, cmd_sel.len};
    assign limit    = (cmd_sel.idx == 2'd0) ? 9'(LongLim) : 9'(ShortLim);
    assign legal    = (cmd_sel.len != 8'd0) && (end_addr <= limit) &&
                      !(gnt[0] && cmd_sel.col && (cmd_sel.idx != 2'd0));

    assign last_beat  = (cnt_reg == len_reg - 8'd1);
    assign issue      = (state_reg == READ);
    assign issue_last = issue && last_beat;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        base_next    = base_reg;
        wsel_next    = wsel_reg;
        wen_next     = 5'd0;
        addr_wr_next = addr_wr_reg;
        dr_next      = dr_reg;
        di_next      = di_reg;
        ren_next     = ren_reg;
        addr_rd_next = addr_rd_reg;
        drain_next   = drain_reg;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_take) begin
                    if (legal) begin
                        len_next  = cmd_sel.len;
                        base_next = cmd_sel.base;
                        cnt_next  = 8'd0;
                        if (gnt[0]) begin
                            state_next = WRITE;
                            wsel_next  = cmd_sel.col ? WEN_COL : (5'd1 << cmd_sel.idx);
                        end else begin
                            // First read address goes out together with the state change.
                            state_next   = READ;
                            ren_next     = cmd_sel.col ? (REN_COL0 << cmd_sel.idx)
                                                       : (8'd1 << cmd_sel.idx);
                            addr_rd_next = cmd_sel.base;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (req.wr_valid_i) begin
                    wen_next     = wsel_reg;
                    addr_wr_next = base_reg + addr_t_long'(cnt_reg);
                    dr_next      = req.wr_dr_i;
                    di_next      = req.wr_di_i;
                    cnt_next     = cnt_reg + 8'd1;
                    if (last_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                if (last_beat) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end else begin
                    addr_rd_next = addr_rd_reg + addr_t_long'(1);
                    cnt_next     = cnt_reg + 8'd1;
                end
            end
            DRAIN: begin
                // ren steers the SRAM output mux, so it holds until the
                // last in-flight beat has returned.
                if (drain_reg == DW'(RdLatency - 1)) begin
                    state_next = IDLE;
                    ren_next   = 8'd0;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            base_reg    <= '0;
            wsel_reg    <= '0;
            wen_reg     <= '0;
            addr_wr_reg <= '0;
            dr_reg      <= '0;
            di_reg      <= '0;
            ren_reg     <= '0;
            addr_rd_reg <= '0;
            drain_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            base_reg    <= base_next;
            wsel_reg    <= wsel_next;
            wen_reg     <= wen_next;
            addr_wr_reg <= addr_wr_next;
            dr_reg      <= dr_next;
            di_reg      <= di_next;
            ren_reg     <= ren_next;
            addr_rd_reg <= addr_rd_next;
            drain_reg   <= drain_next;
            err_reg     <= err_next;
        end
    end

    // Read return tags: one stage per cycle of SRAM read latency.
    generate
        for (genvar gi = 0; gi < RdLatency; gi++) begin : g_vpipe
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vpipe_reg[gi] <= 1'b0;
                    lpipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vpipe_reg[gi] <= issue;
                    lpipe_reg[gi] <= issue_last;
                end else begin
                    vpipe_reg[gi] <= vpipe_reg[(gi == 0) ? 0 : gi - 1];
                    lpipe_reg[gi] <= lpipe_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign req.rd_valid_o = vpipe_reg[RdLatency-1];
    assign req.rd_last_o  = lpipe_reg[RdLatency-1];
    assign req.rd_dr_o    = dr_sram_i;
    assign req.rd_di_o    = di_sram_i;

    assign wen_o     = wen_reg;
    assign addr_wr_o = addr_wr_reg;
    assign dr_sram_o = dr_reg;
    assign di_sram_o = di_reg;
    assign ren_o     = ren_reg;
    assign addr_rd_o = addr_rd_reg;
    assign busy_o    = (state_reg != IDLE);
    assign err_o     = err_reg;

endmodule
